slave_device: RTL and testbench

SLAVE_DEVICE -- requirements
Module: slave_device

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_bus_sync.sv | 65 ++++++
 rtl/slave_device.sv | 178 +++++++++++++++++
 tb/tb_slave_device.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg
// Definitions shared by the I2C slave and the I2C master: the default bus
// address, the slave state encoding and the encoding of detected bus
// conditions (START / STOP) reported by the bus synchronizer.
package i2c_pkg;

   localparam logic [6:0] DEFAULT_ADDRESS = 7'h42;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ADDR      = 3'd1;
   localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
   localparam logic [2:0] ST_RX_DATA   = 3'd3;
   localparam logic [2:0] ST_RX_ACK    = 3'd4;
   localparam logic [2:0] ST_TX_DATA   = 3'd5;
   localparam logic [2:0] ST_TX_ACK    = 3'd6;
   localparam logic [2:0] ST_WAIT_STOP = 3'd7;

   typedef logic [1:0] bus_cond_t;

   localparam bus_cond_t COND_NONE  = 2'd0;
   localparam bus_cond_t COND_START = 2'd1;
   localparam bus_cond_t COND_STOP  = 2'd2;

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync
// Brings the asynchronous scl/sda bus lines into the clk domain and derives
// the events the slave FSM works from.
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   scl, sda    - raw bus lines
//   sda_s       - synchronized sda level
//   scl_rise    - one-clk strobe on a synchronized scl rising edge
//   scl_fall    - one-clk strobe on a synchronized scl falling edge
//   cond        - START / STOP / NONE, valid for one clk
module i2c_bus_sync
   import i2c_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      scl,
   input  logic      sda,
   output logic      sda_s,
   output logic      scl_rise,
   output logic      scl_fall,
   output bus_cond_t cond
);

   logic scl_meta;
   logic scl_s;
   logic scl_d;
   logic sda_meta;
   logic sda_d;

   // Two-flop synchronizers plus one delayed copy of each line for edge
   // detection. Everything resets to 1 so an idle bus looks idle right
   // after reset and no spurious edge is reported.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_meta <= 1'b1;
         scl_s    <= 1'b1;
         scl_d    <= 1'b1;
         sda_meta <= 1'b1;
         sda_s    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_meta <= scl;
         scl_s    <= scl_meta;
         scl_d    <= scl_s;
         sda_meta <= sda;
         sda_s    <= sda_meta;
         sda_d    <= sda_s;
      end
   end

   // START and STOP are sda transitions while scl is held high; requiring
   // scl high in both the current and previous sample keeps a data change
   // that lands next to an scl edge from being mistaken for a condition.
   always_comb begin
      scl_rise = scl_s & ~scl_d;
      scl_fall = ~scl_s & scl_d;
      cond     = COND_NONE;
      if (scl_s && scl_d && sda_d && !sda_s) begin
         cond = COND_START;
      end else if (scl_s && scl_d && !sda_d && sda_s) begin
         cond = COND_STOP;
      end
   end

endmodule

// File: rtl/slave_device.sv
// slave_device
// I2C slave answering to a single 7-bit address. Bytes written by the
// master appear on rx_data with an rx_valid strobe; on reads the byte on
// tx_data is captured at each tx_req strobe and shifted out MSB-first.
// Ports:
//   clk, rst_n - system clock (>= 8x scl), asynchronous active-low reset
//   scl        - bus clock, input only
//   sda        - open-drain data, pulled low or released, never driven high
//   rx_data    - last byte written by the master
//   rx_valid   - one-clk strobe when rx_data updates
//   tx_data    - byte to return on a master read
//   tx_req     - one-clk strobe, tx_data captured on the same clk
//   busy       - addressed and inside a transaction
module slave_device
   import i2c_pkg::*;
#(
   parameter logic [6:0] ADDRESS = DEFAULT_ADDRESS
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl,
   inout  wire        sda,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic       busy
);

   logic       sda_s;
   logic       scl_rise;
   logic       scl_fall;
   bus_cond_t  cond;

   logic [2:0] state;
   logic [2:0] bit_cnt;
   logic [6:0] shift;
   logic       sda_oe;
   logic       rw;
   logic       ack_phase;

   i2c_bus_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .scl      (scl),
      .sda      (sda),
      .sda_s    (sda_s),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .cond     (cond)
   );

   // Open-drain output: the only values ever put on the line are 0 and Z.
   assign sda = sda_oe ? 1'b0 : 1'bz;

   // Protocol FSM. Bus conditions override everything else. Incoming bits
   // are taken on scl rising edges; sda drive only changes on scl falling
   // edges so the line is stable while scl is high. The shift register only
   // holds seven bits: the eighth is consumed directly from sda_s on RX and
   // from tx_data[7] on TX. bit_cnt wraps 0->7 by plain decrement, so byte
   // count per transaction is unbounded. ack_phase separates the falling
   // edge that starts an ACK slot from the one that ends it; in TX_ACK it
   // records that the master acknowledged and another byte is wanted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         bit_cnt   <= 3'd7;
         shift     <= 7'd0;
         sda_oe    <= 1'b0;
         rw        <= 1'b0;
         ack_phase <= 1'b0;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         tx_req    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         tx_req   <= 1'b0;
         if (cond == COND_START) begin
            state     <= ST_ADDR;
            bit_cnt   <= 3'd7;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            ack_phase <= 1'b0;
         end else if (cond == COND_STOP) begin
            state     <= ST_IDLE;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            ack_phase <= 1'b0;
         end else begin
            case (state)
               ST_ADDR: begin
                  if (scl_rise) begin
                     shift   <= {shift[5:0], sda_s};
                     bit_cnt <= bit_cnt - 3'd1;
                     if (bit_cnt == 3'd0) begin
                        if (shift == ADDRESS) begin
                           state     <= ST_ADDR_ACK;
                           rw        <= sda_s;
                           busy      <= 1'b1;
                           ack_phase <= 1'b0;
                        end else begin
                           state <= ST_WAIT_STOP;
                        end
                     end
                  end
               end
               ST_ADDR_ACK, ST_RX_ACK: begin
                  if (scl_fall) begin
                     if (!ack_phase) begin
                        sda_oe    <= 1'b1;
                        ack_phase <= 1'b1;
                     end else begin
                        ack_phase <= 1'b0;
                        bit_cnt   <= 3'd7;
                        if (rw) begin
                           state  <= ST_TX_DATA;
                           tx_req <= 1'b1;
                           shift  <= tx_data[6:0];
                           sda_oe <= ~tx_data[7];
                        end else begin
                           state  <= ST_RX_DATA;
                           sda_oe <= 1'b0;
                        end
                     end
                  end
               end
               ST_RX_DATA: begin
                  if (scl_rise) begin
                     shift   <= {shift[5:0], sda_s};
                     bit_cnt <= bit_cnt - 3'd1;
                     if (bit_cnt == 3'd0) begin
                        rx_data   <= {shift, sda_s};
                        rx_valid  <= 1'b1;
                        state     <= ST_RX_ACK;
                        ack_phase <= 1'b0;
                     end
                  end
               end
               ST_TX_DATA: begin
                  if (scl_fall) begin
                     bit_cnt <= bit_cnt - 3'd1;
                     if (bit_cnt == 3'd0) begin
                        sda_oe    <= 1'b0;
                        state     <= ST_TX_ACK;
                        ack_phase <= 1'b0;
                     end else begin
                        shift  <= {shift[5:0], 1'b0};
                        sda_oe <= ~shift[6];
                     end
                  end
               end
               ST_TX_ACK: begin
                  if (scl_rise) begin
                     if (sda_s) begin
                        state <= ST_WAIT_STOP;
                        busy  <= 1'b0;
                     end else begin
                        ack_phase <= 1'b1;
                     end
                  end else if (scl_fall && ack_phase) begin
                     ack_phase <= 1'b0;
                     bit_cnt   <= 3'd7;
                     state     <= ST_TX_DATA;
                     tx_req    <= 1'b1;
                     shift     <= tx_data[6:0];
                     sda_oe    <= ~tx_data[7];
                  end
               end
               default: begin
                  sda_oe <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_slave_device.sv
// tb_slave_device
// Drives the slave from a behavioural I2C master and compares the bus
// responses and the strobe outputs against expectations derived from the
// I2C transaction rules (address match -> ACK, bytes written appear in
// order, bytes read come back MSB-first).
module tb_slave_device;
   import i2c_pkg::*;

   localparam int H = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl = 1'b1;
   logic       master_sda = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_req;
   logic       busy;
   wire        sda_bus;

   int checks = 0;
   int errors = 0;

   int         rx_cnt = 0;
   int         tx_cnt = 0;
   logic [7:0] rx_q[$];
   bit         busy_seen = 0;
   bit         slave_low = 0;

   pullup (sda_bus);
   assign sda_bus = master_sda ? 1'bz : 1'b0;

   slave_device #(.ADDRESS(DEFAULT_ADDRESS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .scl      (scl),
      .sda      (sda_bus),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_req   (tx_req),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Observe strobes, busy and any slave pull-down once per clk, on the
   // falling edge so registered outputs have settled.
   always @(negedge clk) begin
      if (rx_valid) begin
         rx_q.push_back(rx_data);
         rx_cnt++;
      end
      if (tx_req) tx_cnt++;
      if (busy) busy_seen = 1;
      if (master_sda && sda_bus === 1'b0) slave_low = 1;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic clear_mon();
      rx_q.delete();
      rx_cnt    = 0;
      tx_cnt    = 0;
      busy_seen = 0;
      slave_low = 0;
   endtask

   task automatic write_bit(input logic b);
      #(H/2) master_sda = b;
      #(H/2) scl = 1'b1;
      #(H)   scl = 1'b0;
   endtask

   task automatic read_bit(output logic b);
      master_sda = 1'b1;
      #(H)   scl = 1'b1;
      #(H/2) b = sda_bus;
      #(H/2) scl = 1'b0;
   endtask

   task automatic i2c_start();
      if (scl == 1'b0) begin
         #(H/2) master_sda = 1'b1;
         #(H/2) scl = 1'b1;
      end else begin
         master_sda = 1'b1;
      end
      #(H) master_sda = 1'b0;
      #(H) scl = 1'b0;
   endtask

   task automatic i2c_stop();
      if (scl == 1'b1) begin
         #(H/2) scl = 1'b0;
      end
      #(H/2) master_sda = 1'b0;
      #(H/2) scl = 1'b1;
      #(H)   master_sda = 1'b1;
      #(H);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(b);
      ack = ~b;
   endtask

   task automatic read_byte(output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #30;
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
      checks++; if (tx_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_req: got %b expected 0", tx_req); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx_data: got %h expected 00", rx_data); end
      checks++; if (sda_bus !== 1'b1) begin errors++; $display("[TB] FAIL reset_sda: got %b expected 1", sda_bus); end
      checks++; if (dut.state !== ST_IDLE) begin errors++; $display("[TB] FAIL reset_state: got %0d expected %0d", dut.state, ST_IDLE); end
      rst_n = 1'b1;
      #20;
   endtask

   task automatic test_write_single();
      logic ack;
      clear_mon();
      i2c_start();
      write_byte({DEFAULT_ADDRESS, 1'b0}, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL write_addr_ack: got %b expected 1", ack); end
      write_byte(8'hA5, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL write_data_ack: got %b expected 1", ack); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL write_busy: got %b expected 1", busy); end
      i2c_stop();
      checks++; if (rx_cnt != 1) begin errors++; $display("[TB] FAIL write_rx_valid_count: got %0d expected 1", rx_cnt); end
      checks++; if (rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL write_rx_data: got %h expected a5", rx_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL write_busy_after_stop: got %b expected 0", busy); end
   endtask

   task automatic test_read_nack();
      logic       ack;
      logic [7:0] d;
      clear_mon();
      tx_data = 8'h3C;
      i2c_start();
      write_byte({DEFAULT_ADDRESS, 1'b1}, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL read_addr_ack: got %b expected 1", ack); end
      read_byte(d);
      checks++; if (d !== 8'h3C) begin errors++; $display("[TB] FAIL read_bits: got %h expected 3c", d); end
      write_bit(1'b1);
      #(H);
      checks++; if (tx_cnt != 1) begin errors++; $display("[TB] FAIL read_tx_req_count: got %0d expected 1", tx_cnt); end
      checks++; if (dut.state !== ST_WAIT_STOP) begin errors++; $display("[TB] FAIL read_state_after_nack: got %0d expected %0d", dut.state, ST_WAIT_STOP); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL read_busy_after_nack: got %b expected 0", busy); end
      i2c_stop();
      checks++; if (dut.state !== ST_IDLE) begin errors++; $display("[TB] FAIL read_state_after_stop: got %0d expected %0d", dut.state, ST_IDLE); end
   endtask

   task automatic test_wrong_addr();
      logic ack;
      clear_mon();
      i2c_start();
      write_byte({7'h17, 1'b0}, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL wrong_addr_ack: got %b expected 0", ack); end
      write_byte(8'h5A, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL wrong_addr_data_ack: got %b expected 0", ack); end
      i2c_stop();
      checks++; if (slave_low !== 1'b0) begin errors++; $display("[TB] FAIL wrong_addr_sda_low: got %b expected 0", slave_low); end
      checks++; if (rx_cnt != 0) begin errors++; $display("[TB] FAIL wrong_addr_rx_valid: got %0d expected 0", rx_cnt); end
      checks++; if (busy_seen !== 1'b0) begin errors++; $display("[TB] FAIL wrong_addr_busy: got %b expected 0", busy_seen); end
   endtask

   task automatic test_back_to_back();
      logic ack;
      clear_mon();
      i2c_start();
      write_byte({DEFAULT_ADDRESS, 1'b0}, ack);
      for (int i = 1; i <= 3; i++) begin
         write_byte(8'(i), ack);
         checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ack%0d: got %b expected 1", i, ack); end
      end
      i2c_stop();
      checks++; if (rx_cnt != 3) begin errors++; $display("[TB] FAIL b2b_rx_count: got %0d expected 3", rx_cnt); end
      for (int i = 0; i < rx_q.size() && i < 3; i++) begin
         checks++; if (rx_q[i] !== 8'(i + 1)) begin errors++; $display("[TB] FAIL b2b_rx_byte%0d: got %h expected %h", i, rx_q[i], 8'(i + 1)); end
      end
   endtask

   task automatic test_repeated_start();
      logic       ack;
      logic [7:0] wdat;
      logic [7:0] t0;
      logic [7:0] t1;
      logic [7:0] d;
      clear_mon();
      wdat = 8'($urandom);
      t0   = 8'($urandom);
      t1   = 8'($urandom);
      i2c_start();
      write_byte({DEFAULT_ADDRESS, 1'b0}, ack);
      write_byte(wdat, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL rs_write_ack: got %b expected 1", ack); end
      tx_data = t0;
      i2c_start();
      write_byte({DEFAULT_ADDRESS, 1'b1}, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL rs_read_addr_ack: got %b expected 1", ack); end
      read_byte(d);
      checks++; if (d !== t0) begin errors++; $display("[TB] FAIL rs_read0: got %h expected %h", d, t0); end
      checks++; if (tx_cnt != 1) begin errors++; $display("[TB] FAIL rs_tx_req_first: got %0d expected 1", tx_cnt); end
      tx_data = t1;
      write_bit(1'b0);
      read_byte(d);
      checks++; if (d !== t1) begin errors++; $display("[TB] FAIL rs_read1: got %h expected %h", d, t1); end
      write_bit(1'b1);
      i2c_stop();
      checks++; if (tx_cnt != 2) begin errors++; $display("[TB] FAIL rs_tx_req_total: got %0d expected 2", tx_cnt); end
      checks++; if (rx_cnt != 1 || rx_q.size() != 1 || rx_q[0] !== wdat) begin errors++; $display("[TB] FAIL rs_rx: got count %0d expected 1 with %h", rx_cnt, wdat); end
   endtask

   // Random transactions: address either ours or random, random direction
   // and byte count; expectations come from the transaction rules alone.
   task automatic test_random();
      logic       ack;
      logic [6:0] addr;
      logic       rd;
      logic       match;
      int         n;
      logic [7:0] d;
      logic [7:0] exp_q[$];
      for (int t = 0; t < 8; t++) begin
         clear_mon();
         exp_q.delete();
         addr  = ($urandom_range(0, 1) == 1) ? DEFAULT_ADDRESS : 7'($urandom);
         rd    = 1'($urandom);
         n     = $urandom_range(1, 3);
         match = (addr == DEFAULT_ADDRESS);
         for (int k = 0; k < n; k++) exp_q.push_back(8'($urandom));
         if (rd) tx_data = exp_q[0];
         i2c_start();
         write_byte({addr, rd}, ack);
         checks++; if (ack !== match) begin errors++; $display("[TB] FAIL rnd%0d_addr_ack: got %b expected %b", t, ack, match); end
         for (int k = 0; k < n; k++) begin
            if (rd) begin
               read_byte(d);
               checks++; if (d !== (match ? exp_q[k] : 8'hFF)) begin errors++; $display("[TB] FAIL rnd%0d_read%0d: got %h expected %h", t, k, d, match ? exp_q[k] : 8'hFF); end
               if (k + 1 < n) tx_data = exp_q[k + 1];
               write_bit(k + 1 == n);
            end else begin
               write_byte(exp_q[k], ack);
               checks++; if (ack !== match) begin errors++; $display("[TB] FAIL rnd%0d_data_ack%0d: got %b expected %b", t, k, ack, match); end
            end
         end
         i2c_stop();
         if (rd) begin
            checks++; if (tx_cnt != (match ? n : 0)) begin errors++; $display("[TB] FAIL rnd%0d_tx_req: got %0d expected %0d", t, tx_cnt, match ? n : 0); end
         end else begin
            checks++; if (rx_cnt != (match ? n : 0)) begin errors++; $display("[TB] FAIL rnd%0d_rx_count: got %0d expected %0d", t, rx_cnt, match ? n : 0); end
            for (int k = 0; match && k < n && k < rx_q.size(); k++) begin
               checks++; if (rx_q[k] !== exp_q[k]) begin errors++; $display("[TB] FAIL rnd%0d_rx%0d: got %h expected %h", t, k, rx_q[k], exp_q[k]); end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic       ack;
      logic       b;
      logic [7:0] wdat;
      int         rx_before;
      int         tx_before;
      clear_mon();
      tx_data = 8'hE5;
      i2c_start();
      write_byte({DEFAULT_ADDRESS, 1'b1}, ack);
      for (int i = 0; i < 3; i++) read_bit(b);
      master_sda = 1'b1;
      #(H)   scl = 1'b1;
      #(H/2);
      checks++; if (sda_bus !== 1'b0) begin errors++; $display("[TB] FAIL mid_bit4_driven: got %b expected 0", sda_bus); end
      rx_before = rx_cnt;
      tx_before = tx_cnt;
      rst_n = 1'b0;
      #10;
      checks++; if (sda_bus !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_sda_release: got %b expected 1", sda_bus); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_busy: got %b expected 0", busy); end
      #30 rst_n = 1'b1;
      #20;
      i2c_stop();
      checks++; if (rx_cnt != rx_before || tx_cnt != tx_before) begin errors++; $display("[TB] FAIL mid_reset_pulses: got rx %0d tx %0d expected rx %0d tx %0d", rx_cnt, tx_cnt, rx_before, tx_before); end
      wdat = 8'($urandom);
      clear_mon();
      i2c_start();
      write_byte({DEFAULT_ADDRESS, 1'b0}, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_addr_ack: got %b expected 1", ack); end
      write_byte(wdat, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_data_ack: got %b expected 1", ack); end
      i2c_stop();
      checks++; if (rx_cnt != 1 || rx_data !== wdat) begin errors++; $display("[TB] FAIL post_reset_rx: got %0d pulses data %h expected 1 pulse data %h", rx_cnt, rx_data, wdat); end
   endtask

   initial begin
      #2;
      $display("[TB] starting slave_device bench");
      test_reset();
      test_write_single();
      test_read_nack();
      test_wrong_addr();
      test_back_to_back();
      test_repeated_start();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
